// File: rtl/phase_acc_bank_if.sv
// ============================================================================
// phase_acc_bank_if : slot request / phase result bundle for phase_acc_bank.
// Revision: 1.0   (phase_mod present only when PHASE_MOD_EN is defined)
// ============================================================================
`default_nettype none

interface phase_acc_bank_if #(
    parameter int PHASE_ACC_WIDTH = 20,
    parameter int OUT_WIDTH       = 10,
    parameter int BANK_NUM_WIDTH  = 1,
    parameter int OP_NUM_WIDTH    = 5
);
    logic                       op_valid;
    logic [BANK_NUM_WIDTH-1:0]  bank_num;
    logic [OP_NUM_WIDTH-1:0]    op_num;
    logic [PHASE_ACC_WIDTH-1:0] phase_inc;
    logic                       key_on;
`ifdef PHASE_MOD_EN
    logic [OUT_WIDTH-1:0]       phase_mod;
`endif
    logic                       ready;
    logic [OUT_WIDTH-1:0]       phase_out;
    logic                       phase_valid;

    modport master (
        output op_valid, bank_num, op_num, phase_inc, key_on,
`ifdef PHASE_MOD_EN
        output phase_mod,
`endif
        input  ready, phase_out, phase_valid
    );

    modport slave (
        input  op_valid, bank_num, op_num, phase_inc, key_on,
`ifdef PHASE_MOD_EN
        input  phase_mod,
`endif
        output ready, phase_out, phase_valid
    );
endinterface

`default_nettype wire

// File: rtl/phase_acc_bank.sv
// ============================================================================
// phase_acc_bank : per-operator NCO phase accumulator, RAM-backed, 2-cycle.
// Revision: 1.0   (optional output phase modulation: PHASE_MOD_EN)
// ============================================================================
`default_nettype none

module phase_acc_bank #(
    parameter int PHASE_ACC_WIDTH = 20,
    parameter int OUT_WIDTH       = 10,
    parameter int BANK_NUM_WIDTH  = 1,
    parameter int OP_NUM_WIDTH    = 5
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    phase_acc_bank_if.slave   bus_io
);
    localparam int ADDR_WIDTH = BANK_NUM_WIDTH + OP_NUM_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      init_addr_q, init_addr_d;
    logic                       ready_q, ready_d;
    logic                       w_init_we;

    logic                       s1_valid_q;
    logic [ADDR_WIDTH-1:0]      s1_addr_q;
    logic [PHASE_ACC_WIDTH-1:0] s1_inc_q;
    logic [PHASE_ACC_WIDTH-1:0] s1_old_q;
    logic                       s1_key_q;
`ifdef PHASE_MOD_EN
    logic [OUT_WIDTH-1:0]       s1_mod_q;
`endif
    logic [DEPTH-1:0]           key_prev_q;
    logic [OUT_WIDTH-1:0]       phase_out_q;
    logic                       phase_valid_q;

    logic [PHASE_ACC_WIDTH-1:0] ram_q [DEPTH];

    logic [ADDR_WIDTH-1:0]      w_c0_addr;
    logic                       w_accept;
    logic                       w_fwd;
    logic                       w_key_rise;
    logic [PHASE_ACC_WIDTH-1:0] w_new_acc;
    logic [OUT_WIDTH-1:0]       w_phase_out;
    logic                       w_ram_we;
    logic [ADDR_WIDTH-1:0]      w_ram_waddr;
    logic [PHASE_ACC_WIDTH-1:0] w_ram_wdata;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        w_init_we   = 1'b0;
        ready_d     = (state_q == ST_RUN);
        case (state_q)
            ST_INIT: begin
                w_init_we   = 1'b1;
                init_addr_d = init_addr_q + ADDR_WIDTH'(1);
                if (&init_addr_q) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            ready_q     <= ready_d;
        end
    end

    assign w_c0_addr  = {bus_io.bank_num, bus_io.op_num};
    assign w_accept   = bus_io.op_valid && ready_q;
    // A back-to-back hit on the slot being written must see this cycle's result.
    assign w_fwd      = s1_valid_q && (s1_addr_q == w_c0_addr);
    assign w_key_rise = s1_key_q && !key_prev_q[s1_addr_q];
    assign w_new_acc  = w_key_rise ? '0 : (s1_old_q + s1_inc_q);

`ifdef PHASE_MOD_EN
    assign w_phase_out = w_new_acc[PHASE_ACC_WIDTH-1 -: OUT_WIDTH] + s1_mod_q;
`else
    assign w_phase_out = w_new_acc[PHASE_ACC_WIDTH-1 -: OUT_WIDTH];
`endif

    assign w_ram_we    = w_init_we || s1_valid_q;
    assign w_ram_waddr = w_init_we ? init_addr_q : s1_addr_q;
    assign w_ram_wdata = w_init_we ? '0 : w_new_acc;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            ram_q[w_ram_waddr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_inc_q      <= '0;
            s1_old_q      <= '0;
            s1_key_q      <= 1'b0;
`ifdef PHASE_MOD_EN
            s1_mod_q      <= '0;
`endif
            key_prev_q    <= '0;
            phase_out_q   <= '0;
            phase_valid_q <= 1'b0;
        end else begin
            s1_valid_q    <= w_accept;
            phase_valid_q <= s1_valid_q;
            if (w_accept) begin
                s1_addr_q <= w_c0_addr;
                s1_inc_q  <= bus_io.phase_inc;
                s1_key_q  <= bus_io.key_on;
                s1_old_q  <= w_fwd ? w_new_acc : ram_q[w_c0_addr];
`ifdef PHASE_MOD_EN
                s1_mod_q  <= bus_io.phase_mod;
`endif
            end
            if (s1_valid_q) begin
                key_prev_q[s1_addr_q] <= s1_key_q;
                phase_out_q           <= w_phase_out;
            end
        end
    end

    assign bus_io.ready       = ready_q;
    assign bus_io.phase_out   = phase_out_q;
    assign bus_io.phase_valid = phase_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_acc_bank.sv
// ============================================================================
// tb_phase_acc_bank : randomized + directed bench for phase_acc_bank.
// Revision: 1.0   (define PHASE_MOD_EN to exercise output phase modulation)
// ============================================================================
`default_nettype none

module tb_phase_acc_bank;
    localparam int PAW   = 20;
    localparam int OW    = 10;
    localparam int BW    = 1;
    localparam int OPW   = 5;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    phase_acc_bank_if #(.PHASE_ACC_WIDTH(PAW), .OUT_WIDTH(OW),
                        .BANK_NUM_WIDTH(BW), .OP_NUM_WIDTH(OPW)) bus ();

    phase_acc_bank #(.PHASE_ACC_WIDTH(PAW), .OUT_WIDTH(OW),
                     .BANK_NUM_WIDTH(BW), .OP_NUM_WIDTH(OPW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: slots processed strictly in acceptance order; results appear
    // two edges after the accepting edge; ready 65 edges after reset release.
    logic [PAW-1:0] acc_m [DEPTH];
    bit             kp_m  [DEPTH];
    int             n_edges = 0;
    bit             p1_v = 0, p2_v = 0;
    logic [OW-1:0]  p1_o = '0, p2_o = '0, last_o = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            n_edges = 0;
            p1_v = 0;
            p2_v = 0;
            for (int i = 0; i < DEPTH; i++) begin
                acc_m[i] = '0;
                kp_m[i]  = 1'b0;
            end
        end else begin
            n_edges++;
            p2_v = p1_v;
            p2_o = p1_o;
            p1_v = 0;
            if (bus.op_valid && n_edges >= 66) begin
                int a;
                logic [OW-1:0] o;
                a = int'({bus.bank_num, bus.op_num});
                if (bus.key_on && !kp_m[a]) acc_m[a] = '0;
                else                       acc_m[a] = acc_m[a] + bus.phase_inc;
                kp_m[a] = bus.key_on;
                o = acc_m[a][PAW-1 -: OW];
`ifdef PHASE_MOD_EN
                o = o + bus.phase_mod;
`endif
                p1_v = 1;
                p1_o = o;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ready", bus.ready, 0);
            chk("rst_phase_valid", bus.phase_valid, 0);
            chk("rst_phase_out", bus.phase_out, 0);
            last_o = '0;
        end else begin
            chk("ready", bus.ready, (n_edges >= 65) ? 1 : 0);
            chk("phase_valid", bus.phase_valid, p2_v ? 1 : 0);
            if (p2_v) last_o = p2_o;
            chk("phase_out", bus.phase_out, last_o);
        end
    end

    task automatic drive(input int bank, input int op, input logic [PAW-1:0] inc,
                         input bit key, input logic [OW-1:0] pmod);
        @(posedge clk);
        #2;
        bus.op_valid  = 1'b1;
        bus.bank_num  = BW'(bank);
        bus.op_num    = OPW'(op);
        bus.phase_inc = inc;
        bus.key_on    = key;
`ifdef PHASE_MOD_EN
        bus.phase_mod = pmod;
`else
        if (pmod != '0) bus.key_on = key;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            bus.op_valid = 1'b0;
        end
    endtask

    task automatic pass(input string name, input int bank, input int op,
                        input logic [PAW-1:0] inc, input bit key,
                        input logic [OW-1:0] pmod, input logic [OW-1:0] exp);
        drive(bank, op, inc, key, pmod);
        idle(3);
        chk(name, bus.phase_out, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_ready_now", bus.ready, 0);
        chk("reset_valid_now", bus.phase_valid, 0);
        bus.op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Counts edges from release until ready, pulsing op_valid meanwhile.
    task automatic wait_ready(input string name);
        int k = 0;
        while (!bus.ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            bus.op_valid  = 1'($urandom % 2);
            bus.bank_num  = BW'($urandom);
            bus.op_num    = OPW'($urandom);
            bus.phase_inc = PAW'($urandom);
            bus.key_on    = 1'($urandom % 2);
        end
        bus.op_valid = 1'b0;
        chk(name, k, 65);
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.bank_num  = '0;
        bus.op_num    = '0;
        bus.phase_inc = '0;
        bus.key_on    = 1'b0;
`ifdef PHASE_MOD_EN
        bus.phase_mod = '0;
`endif
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Interrupt the first sweep partway through.
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            bus.op_valid = 1'($urandom % 2);
        end
        do_reset();
        wait_ready("ready_latency_init");

        pass("keyon_p1", 0, 3, 20'h00400, 1'b1, '0, 10'h000);
        pass("keyon_p2", 0, 3, 20'h00400, 1'b1, '0, 10'h001);
        pass("keyon_p3", 0, 3, 20'h00400, 1'b1, '0, 10'h002);
        pass("keyon_p4", 0, 3, 20'h00400, 1'b1, '0, 10'h003);
        chk("model_acc_0_3", acc_m[3], 32'h00C00);

        pass("wrap_p1", 1, 17, 20'h40000, 1'b0, '0, 10'h100);
        pass("wrap_p2", 1, 17, 20'h40000, 1'b0, '0, 10'h200);
        pass("wrap_p3", 1, 17, 20'h40000, 1'b0, '0, 10'h300);
        pass("wrap_p4", 1, 17, 20'h40000, 1'b0, '0, 10'h000);
        pass("wrap_p5", 1, 17, 20'h40000, 1'b0, '0, 10'h100);
        chk("model_acc_1_17", acc_m[49], 32'h40000);
        pass("neg_inc", 1, 18, 20'hFFFFF, 1'b0, '0, 10'h3FF);

        drive(0, 7, 20'h00400, 1'b0, '0);
        drive(0, 7, 20'h00400, 1'b0, '0);
        idle(3);
        chk("fwd_b2b", bus.phase_out, 10'h002);
        drive(0, 8, 20'h00010, 1'b0, '0);
        drive(0, 8, 20'h00010, 1'b0, '0);
        drive(0, 8, 20'h003E0, 1'b0, '0);
        idle(3);
        chk("fwd_small", bus.phase_out, 10'h001);
        chk("model_acc_0_8", acc_m[8], 32'h00400);

        pass("key_1a", 1, 5, 20'h01000, 1'b1, '0, 10'h000);
        pass("key_1b", 1, 5, 20'h01000, 1'b1, '0, 10'h004);
        pass("key_0",  1, 5, 20'h01000, 1'b0, '0, 10'h008);
        pass("key_1c", 1, 5, 20'h01000, 1'b1, '0, 10'h000);

`ifdef PHASE_MOD_EN
        pass("phase_mod", 0, 20, 20'hFC000, 1'b0, 10'h020, 10'h010);
`endif

        // Random traffic concentrated on a few slots to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            int slot;
            slot = ($urandom % 2 == 0) ? int'($urandom % 4) : int'($urandom % DEPTH);
            @(posedge clk);
            #2;
            bus.op_valid  = ($urandom % 10) < 7;
            bus.bank_num  = BW'(slot >> OPW);
            bus.op_num    = OPW'(slot);
            bus.phase_inc = PAW'($urandom);
            bus.key_on    = ($urandom % 4) != 0;
`ifdef PHASE_MOD_EN
            bus.phase_mod = OW'($urandom);
`endif
        end

        // Reset with slots still in flight, then read every slot back.
        do_reset();
        wait_ready("ready_latency_run");
        for (int s = 0; s < DEPTH; s++) begin
            drive(s >> OPW, s % (1 << OPW), 20'hFFFFF, 1'b0, '0);
        end
        idle(3);
        chk("readback_last", bus.phase_out, 10'h3FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
